// File: rtl/switch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : switch_pkg                                              |
// | Shared switch types: write-FSM encoding, tuser bits, widths.     |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
package switch_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ID_WIDTH   = 8;
  localparam int DEF_USER_WIDTH = 17;
  localparam int DEF_RADIX      = 4;
  localparam int DEF_ADDR_WIDTH = 9;

  localparam int USER_BAD_BIT = 0;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_STORE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/switch_iq_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : switch_iq_ram                                           |
// | Simple dual-port RAM, one write port, one registered read port.  |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module switch_iq_ram #(
  parameter int WIDTH      = 102,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/switch_ingress_frame_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : switch_ingress_frame_fifo                               |
// | Store-and-forward ingress frame FIFO; drops bad/oversize frames. |
// | Option : SWITCH_IQ_STATS_EN adds saturating 32-bit counters.     |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module switch_ingress_frame_fifo
  import switch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int USER_WIDTH = DEF_USER_WIDTH,
  parameter int RADIX      = DEF_RADIX,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [RADIX-1:0]      s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [RADIX-1:0]      m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  stat_good,
  output logic                  stat_bad,
  output logic                  stat_overflow
`ifdef SWITCH_IQ_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [31:0]           stat_good_cnt,
  output logic [31:0]           stat_bad_cnt,
  output logic [31:0]           stat_ovf_cnt
`endif
);

  localparam int c_USER_LSB   = 0;
  localparam int c_DEST_LSB   = c_USER_LSB + USER_WIDTH;
  localparam int c_ID_LSB     = c_DEST_LSB + RADIX;
  localparam int c_LAST_BIT   = c_ID_LSB + ID_WIDTH;
  localparam int c_KEEP_LSB   = c_LAST_BIT + 1;
  localparam int c_DATA_LSB   = c_KEEP_LSB + KEEP_WIDTH;
  localparam int c_WORD_WIDTH = c_DATA_LSB + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] c_FULL_XOR = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic [ADDR_WIDTH:0]   w_wr_ptr_inc;
  logic                  w_full, w_empty;
  wr_state_t             r_state;
  logic                  r_drop_ovf;
  logic [ID_WIDTH-1:0]   r_tid, w_wr_tid;
  logic [RADIX-1:0]      r_tdest, w_wr_tdest;
  logic                  w_dest_zero, w_user_bad, w_wr_en;
  logic [c_WORD_WIDTH-1:0] w_wr_word, w_ram_q;
  logic                  r_stat_good, r_stat_bad, r_stat_ovf;

  assign s_axis_tready = 1'b1;
  assign w_full        = (r_wr_ptr ^ r_rd_ptr) == c_FULL_XOR;
  assign w_empty       = r_wr_commit == r_rd_ptr;
  assign w_wr_ptr_inc  = r_wr_ptr + c_PTR_ONE;
  assign w_dest_zero   = s_axis_tdest == '0;
  assign w_user_bad    = s_axis_tuser[USER_BAD_BIT];
  assign w_wr_tid      = (r_state == WR_IDLE) ? s_axis_tid : r_tid;
  assign w_wr_tdest    = (r_state == WR_IDLE) ? s_axis_tdest : r_tdest;
  assign w_wr_word     = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, w_wr_tid, w_wr_tdest, s_axis_tuser};
  // A full buffer never takes a write, so unread committed words stay intact.
  assign w_wr_en = s_axis_tvalid && !w_full &&
                   (((r_state == WR_IDLE) && !w_dest_zero) || (r_state == WR_STORE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WR_IDLE;
      r_drop_ovf  <= 1'b0;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_tid       <= '0;
      r_tdest     <= '0;
      r_stat_good <= 1'b0;
      r_stat_bad  <= 1'b0;
      r_stat_ovf  <= 1'b0;
    end else begin
      r_stat_good <= 1'b0;
      r_stat_bad  <= 1'b0;
      r_stat_ovf  <= 1'b0;
      if (s_axis_tvalid) begin
        case (r_state)
          WR_IDLE: begin
            if (w_dest_zero) begin
              if (s_axis_tlast) r_stat_bad <= 1'b1;
              else begin
                r_state    <= WR_DROP;
                r_drop_ovf <= 1'b0;
              end
            end else if (w_full) begin
              if (s_axis_tlast) r_stat_ovf <= 1'b1;
              else begin
                r_state    <= WR_DROP;
                r_drop_ovf <= 1'b1;
              end
            end else begin
              r_tid   <= s_axis_tid;
              r_tdest <= s_axis_tdest;
              if (!s_axis_tlast) begin
                r_wr_ptr <= w_wr_ptr_inc;
                r_state  <= WR_STORE;
              end else if (w_user_bad) begin
                r_stat_bad <= 1'b1;
              end else begin
                r_wr_ptr    <= w_wr_ptr_inc;
                r_wr_commit <= w_wr_ptr_inc;
                r_stat_good <= 1'b1;
              end
            end
          end
          WR_STORE: begin
            if (w_full) begin
              r_wr_ptr <= r_wr_commit;
              if (s_axis_tlast) begin
                r_stat_ovf <= 1'b1;
                r_state    <= WR_IDLE;
              end else begin
                r_state    <= WR_DROP;
                r_drop_ovf <= 1'b1;
              end
            end else if (s_axis_tlast) begin
              r_state <= WR_IDLE;
              if (w_user_bad) begin
                r_wr_ptr   <= r_wr_commit;
                r_stat_bad <= 1'b1;
              end else begin
                r_wr_ptr    <= w_wr_ptr_inc;
                r_wr_commit <= w_wr_ptr_inc;
                r_stat_good <= 1'b1;
              end
            end else begin
              r_wr_ptr <= w_wr_ptr_inc;
            end
          end
          WR_DROP: begin
            if (s_axis_tlast) begin
              r_stat_ovf <= r_drop_ovf;
              r_stat_bad <= !r_drop_ovf;
              r_state    <= WR_IDLE;
            end
          end
          default: r_state <= WR_IDLE;
        endcase
      end
    end
  end

  assign stat_good     = r_stat_good;
  assign stat_bad      = r_stat_bad;
  assign stat_overflow = r_stat_ovf;

  // Read side: RAM output register feeds an output register backed by one skid slot.
  logic                    r_ram_vld, r_out_vld, r_skid_vld;
  logic [c_WORD_WIDTH-1:0] r_out_word, r_skid_word;
  logic                    w_pop, w_rd_en;
  logic [1:0]              w_occ_after;

  assign w_pop       = r_out_vld && m_axis_tready;
  // Issue a RAM read only when the word landing next cycle is guaranteed a slot.
  assign w_occ_after = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_ram_vld} - {1'b0, w_pop};
  assign w_rd_en     = !w_empty && (w_occ_after <= 2'd1);

  switch_iq_ram #(
    .WIDTH      (c_WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_ram_vld   <= 1'b0;
      r_out_vld   <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_out_word  <= '0;
      r_skid_word <= '0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_ram_vld <= w_rd_en;
      if (!r_out_vld || w_pop) begin
        if (r_skid_vld) begin
          r_out_word <= r_skid_word;
          r_out_vld  <= 1'b1;
          r_skid_vld <= r_ram_vld;
          if (r_ram_vld) r_skid_word <= w_ram_q;
        end else begin
          r_out_vld <= r_ram_vld;
          if (r_ram_vld) r_out_word <= w_ram_q;
        end
      end else if (r_ram_vld) begin
        r_skid_word <= w_ram_q;
        r_skid_vld  <= 1'b1;
      end
    end
  end

  assign m_axis_tvalid = r_out_vld;
  assign m_axis_tdata  = r_out_word[c_DATA_LSB +: DATA_WIDTH];
  assign m_axis_tkeep  = r_out_word[c_KEEP_LSB +: KEEP_WIDTH];
  assign m_axis_tlast  = r_out_word[c_LAST_BIT];
  assign m_axis_tid    = r_out_word[c_ID_LSB +: ID_WIDTH];
  assign m_axis_tdest  = r_out_word[c_DEST_LSB +: RADIX];
  assign m_axis_tuser  = r_out_word[c_USER_LSB +: USER_WIDTH];

`ifdef SWITCH_IQ_STATS_EN
  logic [31:0] r_good_cnt, r_bad_cnt, r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_ovf_cnt  <= '0;
    end else if (stat_clear) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      if (r_stat_good && (r_good_cnt != '1)) r_good_cnt <= r_good_cnt + 32'd1;
      if (r_stat_bad  && (r_bad_cnt  != '1)) r_bad_cnt  <= r_bad_cnt  + 32'd1;
      if (r_stat_ovf  && (r_ovf_cnt  != '1)) r_ovf_cnt  <= r_ovf_cnt  + 32'd1;
    end
  end

  assign stat_good_cnt = r_good_cnt;
  assign stat_bad_cnt  = r_bad_cnt;
  assign stat_ovf_cnt  = r_ovf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_ingress_frame_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_switch_ingress_frame_fifo                            |
// | Scoreboard bench for the ingress frame FIFO (16-word buffer).    |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_switch_ingress_frame_fifo;

  localparam int c_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tid = '0;
  logic [3:0]  s_axis_tdest = '0;
  logic [16:0] s_axis_tuser = '0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [3:0]  m_axis_tdest;
  logic [16:0] m_axis_tuser;
  logic        stat_good, stat_bad, stat_overflow;
`ifdef SWITCH_IQ_STATS_EN
  logic        stat_clear = 1'b0;
  logic [31:0] stat_good_cnt, stat_bad_cnt, stat_ovf_cnt;
`endif

  switch_ingress_frame_fifo #(.ADDR_WIDTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tdest  (s_axis_tdest),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tuser  (m_axis_tuser),
    .stat_good     (stat_good),
    .stat_bad      (stat_bad),
    .stat_overflow (stat_overflow)
`ifdef SWITCH_IQ_STATS_EN
    ,
    .stat_clear    (stat_clear),
    .stat_good_cnt (stat_good_cnt),
    .stat_bad_cnt  (stat_bad_cnt),
    .stat_ovf_cnt  (stat_ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats_out = 0;
  int n_good = 0, n_bad = 0, n_ovf = 0;
  int exp_good = 0, exp_bad = 0, exp_ovf = 0;
  int rdy_mode = 1;
  logic [101:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sink ready pattern: 0 = stalled, 1 = always ready, other = random 50%.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: inputs change just after posedge, so negedge shows what the next edge accepts.
  logic [101:0] prev_word;
  logic         prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [101:0] cur;
    logic [101:0] e;
    cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      n_good += int'(stat_good);
      n_bad  += int'(stat_bad);
      n_ovf  += int'(stat_overflow);
      if (prev_stall) begin
        check("stall_valid_held", {127'd0, m_axis_tvalid}, 128'd1);
        check("stall_word_held", {26'd0, cur}, {26'd0, prev_word});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {26'd0, cur}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", {26'd0, cur}, {26'd0, e});
          beats_out++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = cur;
    end
  end

  // Drives one frame; the reference model decides what it should produce.
  task automatic send_frame(input int len, input logic [3:0] dest, input logic bad,
                            input bit gaps, input bit expect_ok);
    logic [101:0] words[$];
    logic [7:0]   id;
    logic [63:0]  d;
    logic [7:0]   k;
    logic [16:0]  u;
    logic         last;
    int           g;
    id = 8'($urandom);
    for (int i = 0; i < len; i++) begin
      d    = {$urandom, $urandom};
      k    = 8'($urandom);
      u    = 17'($urandom);
      last = (i == len - 1);
      if (last) u[0] = bad;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tuser  = u;
      s_axis_tlast  = last;
      // Later beats carry junk tid/tdest; the first beat's values must stick.
      s_axis_tid    = (i == 0) ? id : 8'($urandom);
      s_axis_tdest  = (i == 0) ? dest : 4'($urandom);
      s_axis_tvalid = 1'b1;
      words.push_back({d, k, last, id, dest, u});
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      if (gaps && !last) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
    end
    if (dest == 4'd0 || bad) exp_bad++;
    else if (expect_ok) begin
      foreach (words[j]) exp_q.push_back(words[j]);
      exp_good++;
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin @(posedge clk); #1; c++; end
    check("drain_remaining", 128'(exp_q.size()), 128'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Guarantees a frame of len words fits, so the model never needs to predict overflow.
  task automatic wait_room(input int len);
    int c = 0;
    while (exp_q.size() + len > c_DEPTH && c < 2000) begin @(posedge clk); #1; c++; end
    if (exp_q.size() + len > c_DEPTH) check("room_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int b0;
    logic any_valid;
    logic [3:0] dst;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
    check("rst_stats", {125'd0, stat_good, stat_bad, stat_overflow}, 128'd0);
    check("rst_tready", {127'd0, s_axis_tready}, 128'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-beat good frame, latency from commit
    rdy_mode = 1;
    b0 = beats_out;
    send_frame(8, 4'b0100, 1'b0, 1'b0, 1'b1);
    check("t1_good_pulse", {127'd0, stat_good}, 128'd1);
    check("t1_valid_c0", {127'd0, m_axis_tvalid}, 128'd0);
    @(posedge clk); #1;
    check("t1_valid_c1", {127'd0, m_axis_tvalid}, 128'd0);
    @(posedge clk); #1;
    check("t1_valid_c2", {127'd0, m_axis_tvalid}, 128'd1);
    wait_drain(100);
    check("t1_beats", 128'(beats_out - b0), 128'd8);

    // Bad frame followed by a good one
    b0 = beats_out;
    send_frame(5, 4'b0010, 1'b1, 1'b0, 1'b1);
    check("t2_bad_pulse", {127'd0, stat_bad}, 128'd1);
    send_frame(3, 4'b1000, 1'b0, 1'b0, 1'b1);
    wait_drain(100);
    check("t2_beats", 128'(beats_out - b0), 128'd3);

    // Destination-less single beat
    send_frame(1, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("t3_bad_pulse", {127'd0, stat_bad}, 128'd1);
    any_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; any_valid |= m_axis_tvalid; end
    check("t3_no_output", {127'd0, any_valid}, 128'd0);

    // Overflow with a stalled sink
    rdy_mode = 0;
    b0 = beats_out;
    send_frame(12, 4'b0001, 1'b0, 1'b0, 1'b1);
    send_frame(10, 4'b0011, 1'b0, 1'b0, 1'b0);
    check("t4_ovf_pulse", {127'd0, stat_overflow}, 128'd1);
    exp_ovf++;
    repeat (10) @(posedge clk);
    #1;
    check("t4_stalled_beats", 128'(beats_out - b0), 128'd0);
    rdy_mode = 1;
    wait_drain(200);
    check("t4_beats", 128'(beats_out - b0), 128'd12);

    // Back-to-back single-beat frames, random ready
    rdy_mode = 2;
    b0 = beats_out;
    for (int i = 0; i < 40; i++) begin
      wait_room(1);
      dst = 4'($urandom_range(1, 15));
      send_frame(1, dst, 1'b0, 1'b0, 1'b1);
    end
    wait_drain(1000);
    check("t5_beats", 128'(beats_out - b0), 128'd40);

    // Random frames: length, gaps, bad flag, empty destination
    for (int i = 0; i < 60; i++) begin
      int len;
      logic bad;
      len = $urandom_range(1, 8);
      bad = ($urandom_range(0, 4) == 0);
      dst = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      wait_room(len);
      send_frame(len, dst, bad, 1'b1, 1'b1);
    end
    wait_drain(2000);
    check("t6_good_count", 128'(n_good), 128'(exp_good));
    check("t6_bad_count", 128'(n_bad), 128'(exp_bad));
    check("t6_ovf_count", 128'(n_ovf), 128'(exp_ovf));

    // Reset mid-frame with a committed frame waiting at the output
    rdy_mode = 0;
    send_frame(2, 4'b0100, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("t7_pending_valid", {127'd0, m_axis_tvalid}, 128'd1);
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = {$urandom, $urandom};
      s_axis_tlast = 1'b0;
      s_axis_tdest = 4'b0001;
      s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t7_rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
    check("t7_rst_stats", {125'd0, stat_good, stat_bad, stat_overflow}, 128'd0);
    check("t7_rst_tready", {127'd0, s_axis_tready}, 128'd1);
    exp_q.delete();
`ifdef SWITCH_IQ_STATS_EN
    check("t7_cnt_zero", 128'(stat_good_cnt), 128'd0);
`endif
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rdy_mode = 1;
    b0 = beats_out;
    send_frame(4, 4'b0010, 1'b0, 1'b0, 1'b1);
    wait_drain(100);
    check("t7_beats", 128'(beats_out - b0), 128'd4);
`ifdef SWITCH_IQ_STATS_EN
    check("t7_cnt_one", 128'(stat_good_cnt), 128'd1);
`endif
    check("final_good_count", 128'(n_good), 128'(exp_good));
    check("final_bad_count", 128'(n_bad), 128'(exp_bad));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
